// File: rtl/user_bitacc_pkg.sv
// user_bitacc_pkg: register map, CTRL field positions and OBI bus structs
// shared by the multi-channel set-bit accumulator.
package user_bitacc_pkg;

   typedef enum logic [1:0] {
      RegAcc  = 2'd0,
      RegPush = 2'd1,
      RegMask = 2'd2,
      RegCtrl = 2'd3
   } reg_e;

   localparam int CtrlMode   = 0;
   localparam int CtrlIrqEn  = 1;
   localparam int CtrlSatEn  = 2;
   localparam int CtrlOvf    = 3;
   localparam int CtrlThresh = 16;
   localparam int ChanStride = 16;
   localparam int IdW        = 4;

   typedef struct packed {
      logic           req;
      logic           we;
      logic [3:0]     be;
      logic [31:0]    addr;
      logic [31:0]    wdata;
      logic [IdW-1:0] aid;
   } sbr_obi_req_t;

   typedef struct packed {
      logic           gnt;
      logic           rvalid;
      logic [31:0]    rdata;
      logic           err;
      logic [IdW-1:0] rid;
   } sbr_obi_rsp_t;

   function automatic logic [31:0] be_mask(input logic [3:0] be);
      for (int i = 0; i < 4; i++) be_mask[8*i+:8] = {8{be[i]}};
   endfunction

endpackage

// File: rtl/user_bitacc_channel.sv
// user_bitacc_channel: one accumulator channel with ACC/MASK/CTRL registers,
// masked popcount adder, saturation/overflow tracking and a threshold interrupt.
module user_bitacc_channel
   import user_bitacc_pkg::*;
#(
   parameter int AccWidth = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we,
   input  reg_e        sel,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic [31:0] acc_rd,
   output logic [31:0] mask_rd,
   output logic [31:0] ctrl_rd,
   output logic        irq
);
   logic [AccWidth-1:0] acc, acc_n, thresh, thresh_n, tm;
   logic [31:0] mask, mask_n, bm, pick;
   logic [AccWidth:0] sum;
   logic mode, irq_en, sat_en, ovf, mode_n, irq_en_n, sat_en_n, ovf_n;
   logic push, wacc, wctrl;

   always_comb begin
      bm = be_mask(be);
      push = we && sel == RegPush;
      wacc = we && sel == RegAcc;
      wctrl = we && sel == RegCtrl;
      acc_rd = 32'(acc);
      mask_rd = mask;
      ctrl_rd = '0;
      ctrl_rd[CtrlMode] = mode;
      ctrl_rd[CtrlIrqEn] = irq_en;
      ctrl_rd[CtrlSatEn] = sat_en;
      ctrl_rd[CtrlOvf] = ovf;
      ctrl_rd[CtrlThresh+:AccWidth] = thresh;
      pick = (mode ? ~wdata : wdata) & mask & bm;
      sum = {1'b0, acc} + (AccWidth+1)'($countones(pick));
      acc_n = push ? ((sum[AccWidth] && sat_en) ? '1 : sum[AccWidth-1:0])
            : wacc ? (acc & ~bm[AccWidth-1:0]) | (wdata[AccWidth-1:0] & bm[AccWidth-1:0])
            : acc;
      mask_n = (we && sel == RegMask) ? (mask & ~bm) | (wdata & bm) : mask;
      tm = bm[CtrlThresh+:AccWidth];
      thresh_n = wctrl ? (thresh & ~tm) | (wdata[CtrlThresh+:AccWidth] & tm) : thresh;
      mode_n = (wctrl && be[0]) ? wdata[CtrlMode] : mode;
      irq_en_n = (wctrl && be[0]) ? wdata[CtrlIrqEn] : irq_en;
      sat_en_n = (wctrl && be[0]) ? wdata[CtrlSatEn] : sat_en;
      // a PUSH and a CTRL write never share a cycle on one channel, so W1C and set cannot collide here
      ovf_n = (push && sum[AccWidth]) || (ovf && !(wctrl && be[0] && wdata[CtrlOvf]));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc <= '0;
         mask <= '1;
         thresh <= '0;
         {mode, irq_en, sat_en, ovf, irq} <= '0;
      end else begin
         acc <= acc_n;
         mask <= mask_n;
         thresh <= thresh_n;
         {mode, irq_en, sat_en, ovf} <= {mode_n, irq_en_n, sat_en_n, ovf_n};
         irq <= irq_en_n && acc_n >= thresh_n;
      end
   end
endmodule

// File: rtl/user_bitacc_multi.sv
// user_bitacc_multi: OBI subordinate fronting NumChannels set-bit accumulators;
// address decode, registered single-cycle response and read mux.
module user_bitacc_multi
   import user_bitacc_pkg::*;
#(
   parameter int  NumChannels = 4,
   parameter int  AccWidth    = 16,
   parameter type obi_req_t   = sbr_obi_req_t,
   parameter type obi_rsp_t   = sbr_obi_rsp_t
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  obi_req_t               obi_req_i,
   output obi_rsp_t               obi_rsp_o,
   output logic [NumChannels-1:0] irq_o
);
   localparam int ChIdxW = NumChannels > 1 ? $clog2(NumChannels) : 1;

   logic [31:0] acc_rd [NumChannels];
   logic [31:0] mask_rd [NumChannels];
   logic [31:0] ctrl_rd [NumChannels];
   logic [ChIdxW-1:0] ch;
   reg_e rsel;
   logic hit, rvalid, err, unused_addr;
   logic [31:0] rdata, rdata_n;
   logic [IdW-1:0] rid;

   assign unused_addr = ^obi_req_i.addr[1:0];

   // the whole index above the register field is compared, so any address past the last channel errors
   always_comb begin
      ch = obi_req_i.addr[4+:ChIdxW];
      rsel = reg_e'(obi_req_i.addr[3:2]);
      hit = obi_req_i.addr[31:4] < 28'(NumChannels);
      rdata_n = !hit ? '0
              : rsel == RegAcc ? acc_rd[ch]
              : rsel == RegMask ? mask_rd[ch]
              : rsel == RegCtrl ? ctrl_rd[ch]
              : '0;
      obi_rsp_o = '0;
      obi_rsp_o.gnt = obi_req_i.req;
      obi_rsp_o.rvalid = rvalid;
      obi_rsp_o.rdata = rdata;
      obi_rsp_o.err = err;
      obi_rsp_o.rid = rid;
   end

   for (genvar c = 0; c < NumChannels; c++) begin : g_ch
      user_bitacc_channel #(.AccWidth(AccWidth)) u_ch (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .we      (obi_req_i.req && obi_req_i.we && hit && ch == ChIdxW'(c)),
         .sel     (rsel),
         .be      (obi_req_i.be),
         .wdata   (obi_req_i.wdata),
         .acc_rd  (acc_rd[c]),
         .mask_rd (mask_rd[c]),
         .ctrl_rd (ctrl_rd[c]),
         .irq     (irq_o[c])
      );
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid <= 1'b0;
         rdata <= '0;
         err <= 1'b0;
         rid <= '0;
      end else begin
         rvalid <= obi_req_i.req;
         if (obi_req_i.req) begin
            rdata <= rdata_n;
            err <= !hit;
            rid <= obi_req_i.aid;
         end
      end
   end
endmodule

// File: tb/tb_user_bitacc_multi.sv
// tb_user_bitacc_multi: directed register scenarios plus random OBI traffic,
// checked against an arithmetic model of the accumulator channels.
module tb_user_bitacc_multi;
   import user_bitacc_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   sbr_obi_req_t req;
   sbr_obi_rsp_t rsp;
   logic [3:0] irq_o;

   int n_chk = 0;
   int n_pass = 0;

   logic [15:0] m_acc [4];
   logic [31:0] m_mask [4];
   logic [15:0] m_thr [4];
   logic m_mode [4], m_ien [4], m_sat [4], m_ovf [4];

   user_bitacc_multi #(.NumChannels(4), .AccWidth(16)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .obi_req_i (req),
      .obi_rsp_o (rsp),
      .irq_o     (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] ctrl_img(input int c);
      return {m_thr[c], 12'h0, m_ovf[c], m_sat[c], m_ien[c], m_mode[c]};
   endfunction

   function automatic logic [3:0] irq_exp();
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = m_ien[c] && (m_acc[c] >= m_thr[c]);
      return v;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         m_acc[c] = 0;
         m_mask[c] = 32'hFFFF_FFFF;
         m_thr[c] = 0;
         {m_mode[c], m_ien[c], m_sat[c], m_ovf[c]} = '0;
      end
   endtask

   task automatic model_write(input int c, input int r, input logic [3:0] be, input logic [31:0] wd);
      logic [31:0] bm, t;
      int s;
      for (int i = 0; i < 4; i++) bm[8*i+:8] = {8{be[i]}};
      case (r)
         0: begin
            t = ({16'h0, m_acc[c]} & ~bm) | (wd & bm);
            m_acc[c] = t[15:0];
         end
         1: begin
            s = int'(m_acc[c]) + $countones((m_mode[c] ? ~wd : wd) & m_mask[c] & bm);
            if (s > 65535) begin
               m_ovf[c] = 1'b1;
               m_acc[c] = m_sat[c] ? 16'hFFFF : 16'(s - 65536);
            end else m_acc[c] = 16'(s);
         end
         2: m_mask[c] = (m_mask[c] & ~bm) | (wd & bm);
         default: begin
            t = (ctrl_img(c) & ~bm) | (wd & bm);
            m_mode[c] = t[0];
            m_ien[c] = t[1];
            m_sat[c] = t[2];
            m_thr[c] = t[31:16];
            if (be[0] && wd[3]) m_ovf[c] = 1'b0;
         end
      endcase
   endtask

   task automatic xfer(input int c, input int r, input bit we, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd);
      logic [31:0] exp_rd;
      logic [3:0] aid;
      bit exp_err;
      aid = 4'($urandom);
      exp_err = c >= 4;
      exp_rd = exp_err ? 32'h0 : r == 0 ? {16'h0, m_acc[c]} : r == 2 ? m_mask[c] : r == 3 ? ctrl_img(c) : 32'h0;
      @(negedge clk_i);
      req.req = 1'b1;
      req.we = we;
      req.be = be;
      req.addr = 32'(c * 16 + r * 4) + 32'($urandom_range(0, 3));
      req.wdata = wd;
      req.aid = aid;
      #1 chk("gnt", 32'(rsp.gnt), 32'd1);
      if (!exp_err && we) model_write(c, r, be, wd);
      @(posedge clk_i);
      #1 req.req = 1'b0;
      rd = rsp.rdata;
      chk("rvalid", 32'(rsp.rvalid), 32'd1);
      chk("rdata", rsp.rdata, exp_rd);
      chk("err", 32'(rsp.err), 32'(exp_err));
      chk("rid", 32'(rsp.rid), 32'(aid));
      chk("irq", 32'(irq_o), 32'(irq_exp()));
      @(posedge clk_i);
      #1 chk("rvalid_drop", 32'(rsp.rvalid), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] wd;
      req = '0;
      model_reset();
      repeat (3) @(posedge clk_i);
      #1 chk("rst_rvalid", 32'(rsp.rvalid), 32'd0);
      chk("rst_rdata", rsp.rdata, 32'd0);
      chk("rst_err", 32'(rsp.err), 32'd0);
      chk("rst_irq", 32'(irq_o), 32'd0);
      @(negedge clk_i) rst_i = 1'b0;
      xfer(0, 0, 0, 4'hF, 0, rd); chk("ch0_acc_rst", rd, 32'h0);
      xfer(0, 2, 0, 4'hF, 0, rd); chk("ch0_mask_rst", rd, 32'hFFFF_FFFF);
      xfer(0, 3, 0, 4'hF, 0, rd); chk("ch0_ctrl_rst", rd, 32'h0);
      xfer(1, 1, 1, 4'hF, 32'h0000_00FF, rd);
      xfer(1, 1, 1, 4'hF, 32'hF000_0000, rd);
      xfer(1, 0, 0, 4'hF, 0, rd); chk("ch1_acc12", rd, 32'd12);
      for (int c = 0; c < 4; c += 2) begin
         xfer(c, 0, 0, 4'hF, 0, rd); chk("other_acc0", rd, 32'd0);
      end
      xfer(3, 0, 0, 4'hF, 0, rd); chk("ch3_acc0", rd, 32'd0);
      xfer(2, 2, 1, 4'hF, 32'h0000_FFFF, rd);
      xfer(2, 3, 1, 4'hF, 32'h1, rd);
      xfer(2, 1, 1, 4'b0001, 32'h0000_00F0, rd);
      xfer(2, 1, 0, 4'hF, 0, rd); chk("push_rd0", rd, 32'd0);
      xfer(2, 0, 0, 4'hF, 0, rd); chk("ch2_acc4", rd, 32'd4);
      xfer(3, 0, 1, 4'hF, 32'hFFF0, rd);
      xfer(3, 3, 1, 4'hF, 32'h4, rd);
      xfer(3, 1, 1, 4'hF, 32'hFFFF_FFFF, rd);
      xfer(3, 0, 0, 4'hF, 0, rd); chk("sat_acc", rd, 32'hFFFF);
      xfer(3, 3, 0, 4'hF, 0, rd); chk("sat_ovf", rd, 32'hC);
      xfer(3, 3, 1, 4'hF, 32'h0, rd);
      xfer(3, 0, 1, 4'hF, 32'hFFEF, rd);
      xfer(3, 1, 1, 4'hF, 32'hFFFF_FFFF, rd);
      xfer(3, 0, 0, 4'hF, 0, rd); chk("wrap_acc", rd, 32'h000F);
      xfer(3, 3, 1, 4'hF, 32'h8, rd);
      xfer(3, 3, 0, 4'hF, 0, rd); chk("ovf_clr", rd, 32'h0);
      xfer(0, 3, 1, 4'hF, 32'h000A_0002, rd);
      xfer(0, 1, 1, 4'hF, 32'h3FF, rd);
      chk("irq0_set", 32'(irq_o[0]), 32'd1);
      xfer(0, 0, 1, 4'hF, 32'h0, rd);
      chk("irq0_clr", 32'(irq_o[0]), 32'd0);
      xfer(7, 0, 0, 4'hF, 0, rd); chk("bad_ch_rdata", rd, 32'h0);
      xfer(7, 0, 1, 4'hF, 32'h1234, rd);
      for (int i = 0; i < 400; i++) begin
         wd = ($urandom_range(0, 3) == 0) ? {16'h0, 16'hFFC0 | 16'($urandom_range(0, 63))} : $urandom;
         xfer($urandom_range(0, 4) == 4 ? $urandom_range(4, 7) : $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom), 4'($urandom), wd, rd);
      end
      @(negedge clk_i);
      req.req = 1'b1; req.we = 1'b0; req.addr = 32'h10; req.be = 4'hF;
      @(posedge clk_i);
      #1 req.req = 1'b0;
      chk("pend_rvalid", 32'(rsp.rvalid), 32'd1);
      rst_i = 1'b1;
      #1 chk("rst_drop_rvalid", 32'(rsp.rvalid), 32'd0);
      chk("rst_drop_irq", 32'(irq_o), 32'd0);
      model_reset();
      @(negedge clk_i) rst_i = 1'b0;
      @(posedge clk_i);
      #1 chk("idle_rvalid", 32'(rsp.rvalid), 32'd0);
      xfer(1, 0, 0, 4'hF, 0, rd); chk("ch1_after_rst", rd, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
